regfile_sb: RTL and testbench

Parametrised multi-port register file with an integrated busy scoreboard, the successor to the single-write, two-read register file in the single-cycle core. It serves the pipelined core: decode reads operands and busy flags, the issue stage marks destination registers busy, and two writeback ports (ALU and load/store) update registers and clear their busy flags. Register 0 is optionally hardwired to zero, and same-cycle write-to-read bypass is selectable.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_bypass_mux.sv | 46 ++++
 rtl/regfile_sb.sv | 105 ++++++++++
 tb/tb_regfile_sb.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;

   localparam int XLEN_D   = 32;
   localparam int NREG_D   = 32;
   localparam int REG_ZERO = 0;

   // Address width for a register count; a single register still needs one bit.
   function automatic int aw_of(input int nreg);
      return (nreg > 1) ? $clog2(nreg) : 1;
   endfunction

endpackage

// File: rtl/regfile_bypass_mux.sv
// Per-read-port selection between stored state and in-flight writebacks,
// with the hardwired-zero override applied last.
module regfile_bypass_mux
   import regfile_pkg::*;
#(
   parameter int XLEN     = XLEN_D,
   parameter int AW       = aw_of(NREG_D),
   parameter bit BYPASS   = 1'b1,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic [AW-1:0]   rd_addr,
   input  logic [XLEN-1:0] mem_data,
   input  logic            mem_busy,
   input  logic            w0_en,
   input  logic [AW-1:0]   w0_addr,
   input  logic [XLEN-1:0] w0_data,
   input  logic            w1_en,
   input  logic [AW-1:0]   w1_addr,
   input  logic [XLEN-1:0] w1_data,
   input  logic            iss_en,
   input  logic [AW-1:0]   iss_addr,
   output logic [XLEN-1:0] rd_data,
   output logic            rd_busy
);

   // Port 1 outranks port 0 so the bypassed value matches what the edge stores;
   // busy shows the post-edge value, where a same-cycle issue re-marks it.
   always_comb begin
      rd_data = mem_data;
      rd_busy = mem_busy;
      if (BYPASS) begin
         if (w1_en && (w1_addr == rd_addr)) begin
            rd_data = w1_data;
            rd_busy = iss_en && (iss_addr == rd_addr);
         end else if (w0_en && (w0_addr == rd_addr)) begin
            rd_data = w0_data;
            rd_busy = iss_en && (iss_addr == rd_addr);
         end
      end
      if (ZERO_REG && (rd_addr == AW'(REG_ZERO))) begin
         rd_data = '0;
         rd_busy = 1'b0;
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read, dual-writeback register file with a per-register busy scoreboard.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int  XLEN     = XLEN_D,
   parameter int  NREG     = NREG_D,
   parameter int  NRD      = 2,
   parameter bit  BYPASS   = 1'b1,
   parameter bit  ZERO_REG = 1'b1,
   localparam int AW       = aw_of(NREG)
) (
   input  logic                clk,
   input  logic                clr,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                w0_en,
   input  logic [AW-1:0]       w0_addr,
   input  logic [XLEN-1:0]     w0_data,
   input  logic                w1_en,
   input  logic [AW-1:0]       w1_addr,
   input  logic [XLEN-1:0]     w1_data,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_addr,
   output logic                busy_any
);

   logic [XLEN-1:0] mem_q [NREG];
   logic [XLEN-1:0] mem_d [NREG];
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;

   // Enables are dead while clr is high so the bypass path also reads zero.
   logic w0_live, w1_live, iss_live;
   logic w0_eff, w1_eff, iss_eff;

   // Qualify enables with reset and drop anything aimed at the zero register.
   always_comb begin
      w0_live  = w0_en  && !clr;
      w1_live  = w1_en  && !clr;
      iss_live = iss_en && !clr;
      w0_eff   = w0_live  && !(ZERO_REG && (w0_addr  == AW'(REG_ZERO)));
      w1_eff   = w1_live  && !(ZERO_REG && (w1_addr  == AW'(REG_ZERO)));
      iss_eff  = iss_live && !(ZERO_REG && (iss_addr == AW'(REG_ZERO)));
   end

   // Next state: port 0, then port 1 (wins a collision), then issue (wins over clear).
   always_comb begin
      mem_d  = mem_q;
      busy_d = busy_q;
      if (w0_eff) begin
         mem_d[w0_addr]  = w0_data;
         busy_d[w0_addr] = 1'b0;
      end
      if (w1_eff) begin
         mem_d[w1_addr]  = w1_data;
         busy_d[w1_addr] = 1'b0;
      end
      if (iss_eff) begin
         busy_d[iss_addr] = 1'b1;
      end
   end

   // Storage and scoreboard flops; clr wipes everything without waiting for a clock.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int i = 0; i < NREG; i++) begin
            mem_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         mem_q  <= mem_d;
         busy_q <= busy_d;
      end
   end

   assign busy_any = |busy_q;

   for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0] addr;
      assign addr = rd_addr[gi*AW +: AW];

      regfile_bypass_mux #(
         .XLEN     (XLEN),
         .AW       (AW),
         .BYPASS   (BYPASS),
         .ZERO_REG (ZERO_REG)
      ) u_mux (
         .rd_addr  (addr),
         .mem_data (mem_q[addr]),
         .mem_busy (busy_q[addr]),
         .w0_en    (w0_live),
         .w0_addr  (w0_addr),
         .w0_data  (w0_data),
         .w1_en    (w1_live),
         .w1_addr  (w1_addr),
         .w1_data  (w1_data),
         .iss_en   (iss_live),
         .iss_addr (iss_addr),
         .rd_data  (rd_data[gi*XLEN +: XLEN]),
         .rd_busy  (rd_busy[gi])
      );
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed and randomized checks of regfile_sb: a bypassing instance and a
// non-bypassing instance share one directed stimulus, and a wide 4-port
// instance is swept against a reference model.
module tb_regfile_sb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic clr;

   // Shared stimulus for the default-parameter instances (A: BYPASS=1, B: BYPASS=0)
   logic [9:0]  s_rd_addr;
   logic        s_w0_en, s_w1_en, s_iss_en;
   logic [4:0]  s_w0_addr, s_w1_addr, s_iss_addr;
   logic [31:0] s_w0_data, s_w1_data;
   logic [63:0] a_rd_data, b_rd_data;
   logic [1:0]  a_rd_busy, b_rd_busy;
   logic        a_busy_any, b_busy_any;

   // Sweep instance C: NRD=4, XLEN=64, NREG=16
   logic [15:0]  w_rd_addr;
   logic         w_w0_en, w_w1_en, w_iss_en;
   logic [3:0]   w_w0_addr, w_w1_addr, w_iss_addr;
   logic [63:0]  w_w0_data, w_w1_data;
   logic [255:0] c_rd_data;
   logic [3:0]   c_rd_busy;
   logic         c_busy_any;

   regfile_sb #(.BYPASS(1'b1)) u_a (
      .clk(clk), .clr(clr), .rd_addr(s_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
      .w0_en(s_w0_en), .w0_addr(s_w0_addr), .w0_data(s_w0_data),
      .w1_en(s_w1_en), .w1_addr(s_w1_addr), .w1_data(s_w1_data),
      .iss_en(s_iss_en), .iss_addr(s_iss_addr), .busy_any(a_busy_any)
   );

   regfile_sb #(.BYPASS(1'b0)) u_b (
      .clk(clk), .clr(clr), .rd_addr(s_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
      .w0_en(s_w0_en), .w0_addr(s_w0_addr), .w0_data(s_w0_data),
      .w1_en(s_w1_en), .w1_addr(s_w1_addr), .w1_data(s_w1_data),
      .iss_en(s_iss_en), .iss_addr(s_iss_addr), .busy_any(b_busy_any)
   );

   regfile_sb #(.XLEN(64), .NREG(16), .NRD(4)) u_c (
      .clk(clk), .clr(clr), .rd_addr(w_rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
      .w0_en(w_w0_en), .w0_addr(w_w0_addr), .w0_data(w_w0_data),
      .w1_en(w_w1_en), .w1_addr(w_w1_addr), .w1_data(w_w1_data),
      .iss_en(w_iss_en), .iss_addr(w_iss_addr), .busy_any(c_busy_any)
   );

   // Scoreboard: kind 0 = rd_data, 1 = rd_busy, 2 = busy_any
   typedef struct {
      int          inst;
      int          kind;
      int          port;
      logic [63:0] exp;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   step_no  = 0;

   logic [63:0] m_mem [16];
   logic [15:0] m_busy;

   function automatic logic [63:0] observe(input int inst, input int kind, input int port);
      logic [63:0] v;
      v = '0;
      case (inst)
         0: begin
            if (kind == 0)      v = {32'h0, a_rd_data[port*32 +: 32]};
            else if (kind == 1) v = {63'h0, a_rd_busy[port]};
            else                v = {63'h0, a_busy_any};
         end
         1: begin
            if (kind == 0)      v = {32'h0, b_rd_data[port*32 +: 32]};
            else if (kind == 1) v = {63'h0, b_rd_busy[port]};
            else                v = {63'h0, b_busy_any};
         end
         default: begin
            if (kind == 0)      v = c_rd_data[port*64 +: 64];
            else if (kind == 1) v = {63'h0, c_rd_busy[port]};
            else                v = {63'h0, c_busy_any};
         end
      endcase
      return v;
   endfunction

   task automatic push(input int inst, input int kind, input int port, input logic [63:0] e);
      exp_t t;
      t.inst = inst;
      t.kind = kind;
      t.port = port;
      t.exp  = e;
      sb_q.push_back(t);
   endtask

   task automatic exp_rd(input int inst, input int port, input logic [63:0] d, input logic b);
      push(inst, 0, port, d);
      push(inst, 1, port, {63'h0, b});
   endtask

   task automatic exp_both(input int port, input logic [63:0] d, input logic b);
      exp_rd(0, port, d, b);
      exp_rd(1, port, d, b);
   endtask

   task automatic exp_any(input int inst, input logic b);
      push(inst, 2, 0, {63'h0, b});
   endtask

   // Let combinational reads settle, then pop and compare every queued expectation.
   task automatic settle();
      exp_t        t;
      logic [63:0] obs;
      string       kn;
      #1;
      while (sb_q.size() > 0) begin
         t   = sb_q.pop_front();
         obs = observe(t.inst, t.kind, t.port);
         kn  = (t.kind == 0) ? "rd_data" : ((t.kind == 1) ? "rd_busy" : "busy_any");
         n_checks++;
         assert (obs === t.exp) else begin
            n_errors++;
            $error("FAIL step%0d inst%0d %s port%0d observed=%h expected=%h",
                   step_no, t.inst, kn, t.port, obs, t.exp);
         end
      end
   endtask

   task automatic idle();
      s_w0_en = 1'b0; s_w1_en = 1'b0; s_iss_en = 1'b0;
      w_w0_en = 1'b0; w_w1_en = 1'b0; w_iss_en = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      step_no++;
      idle();
   endtask

   task automatic rd(input int k, input int a);
      s_rd_addr[k*5 +: 5] = 5'(a);
   endtask

   task automatic wr0(input int a, input logic [31:0] d);
      s_w0_en = 1'b1; s_w0_addr = 5'(a); s_w0_data = d;
   endtask

   task automatic wr1(input int a, input logic [31:0] d);
      s_w1_en = 1'b1; s_w1_addr = 5'(a); s_w1_data = d;
   endtask

   task automatic iss(input int a);
      s_iss_en = 1'b1; s_iss_addr = 5'(a);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      clr = 1'b1;
      s_rd_addr = '0; s_w0_addr = '0; s_w1_addr = '0; s_iss_addr = '0;
      s_w0_data = '0; s_w1_data = '0;
      w_rd_addr = '0; w_w0_addr = '0; w_w1_addr = '0; w_iss_addr = '0;
      w_w0_data = '0; w_w1_data = '0;
      idle();

      // 1: reset held, write and issue presented -> nothing visible
      @(posedge clk); #1; step_no = 1;
      wr0(5, 32'hDEADBEEF); iss(5); rd(0, 5); rd(1, 0);
      exp_both(0, 64'h0, 1'b0); exp_both(1, 64'h0, 1'b0);
      exp_any(0, 1'b0); exp_any(1, 1'b0); exp_any(2, 1'b0);
      settle();

      // 2: the edge under reset stored nothing; release reset and write r5
      step();
      exp_both(0, 64'h0, 1'b0); settle();
      clr = 1'b0;
      wr0(5, 32'hDEADBEEF);
      exp_rd(0, 0, 64'hDEADBEEF, 1'b0); exp_rd(1, 0, 64'h0, 1'b0);
      settle();

      // 3: r5 visible everywhere; write to r0 is discarded
      step();
      wr0(0, 32'h1234);
      exp_both(0, 64'hDEADBEEF, 1'b0); exp_both(1, 64'h0, 1'b0);
      settle();

      // 4: r0 still zero; both ports hit r7, port 1 wins
      step();
      rd(0, 7);
      wr0(7, 32'hAAAA); wr1(7, 32'h5555);
      exp_both(1, 64'h0, 1'b0);
      exp_rd(0, 0, 64'h5555, 1'b0); exp_rd(1, 0, 64'h0, 1'b0);
      settle();

      // 5: r7 stored port 1's data; write r9 while reading it
      step();
      rd(1, 9); wr0(9, 32'h77);
      exp_both(0, 64'h5555, 1'b0);
      exp_rd(0, 1, 64'h77, 1'b0); exp_rd(1, 1, 64'h0, 1'b0);
      settle();

      // 6: r9 visible in both; issue r3 (busy is registered, not yet visible)
      step();
      rd(0, 3); iss(3);
      exp_both(1, 64'h77, 1'b0); exp_both(0, 64'h0, 1'b0);
      exp_any(0, 1'b0); exp_any(1, 1'b0);
      settle();

      // 7: r3 busy; port 1 writeback to r3
      step();
      wr1(3, 32'h3333);
      exp_any(0, 1'b1); exp_any(1, 1'b1);
      exp_rd(0, 0, 64'h3333, 1'b0); exp_rd(1, 0, 64'h0, 1'b1);
      settle();

      // 8: busy cleared; reissue r3 in the same cycle as a port 0 write
      step();
      exp_both(0, 64'h3333, 1'b0); exp_any(0, 1'b0); exp_any(1, 1'b0);
      settle();
      iss(3); wr0(3, 32'hCAFE);
      exp_rd(0, 0, 64'hCAFE, 1'b1); exp_rd(1, 0, 64'h3333, 1'b0);
      settle();

      // 9: issue wins over the clear; issue to r0 is ignored
      step();
      rd(1, 0); iss(0);
      exp_both(0, 64'hCAFE, 1'b1); exp_both(1, 64'h0, 1'b0);
      exp_any(0, 1'b1); exp_any(1, 1'b1);
      settle();

      // 10: retire r3
      step();
      wr0(3, 32'h10);
      exp_rd(0, 0, 64'h10, 1'b0); exp_rd(1, 0, 64'hCAFE, 1'b1);
      settle();

      // 11: nothing busy, so r0 never became busy; issue r4
      step();
      iss(4);
      exp_both(0, 64'h10, 1'b0); exp_both(1, 64'h0, 1'b0);
      exp_any(0, 1'b0); exp_any(1, 1'b0);
      settle();

      // 12: r4 busy; issue r6
      step();
      rd(0, 4); rd(1, 6); iss(6);
      exp_both(0, 64'h0, 1'b1); exp_both(1, 64'h0, 1'b0);
      settle();

      // 13: r4 and r6 busy, then reset between edges with writes pending
      step();
      wr0(9, 32'h99);
      exp_both(0, 64'h0, 1'b1); exp_any(0, 1'b1); exp_any(1, 1'b1);
      settle();
      #2;
      wr0(6, 32'h6666); wr1(4, 32'h4444); iss(9);
      #1;
      clr = 1'b1;
      exp_both(0, 64'h0, 1'b0); exp_both(1, 64'h0, 1'b0);
      exp_any(0, 1'b0); exp_any(1, 1'b0);
      rd(1, 9);
      exp_both(1, 64'h0, 1'b0);
      settle();

      // 14: edge under reset with writes still applied; release and confirm nothing landed
      @(posedge clk); #1; step_no++;
      clr = 1'b0;
      idle();
      rd(0, 6); rd(1, 4);
      exp_both(0, 64'h0, 1'b0); exp_both(1, 64'h0, 1'b0);
      exp_any(0, 1'b0); exp_any(1, 1'b0);
      settle();

      // 15: earlier contents are gone too
      step();
      rd(0, 5); rd(1, 9);
      exp_both(0, 64'h0, 1'b0); exp_both(1, 64'h0, 1'b0);
      settle();

      // Sweep of the wide instance against a reference model
      for (int i = 0; i < 16; i++) m_mem[i] = '0;
      m_busy = '0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         step();
         w_w0_en   = 1'($urandom_range(0, 1));
         w_w0_addr = 4'($urandom_range(0, 15));
         w_w0_data = {$urandom, $urandom};
         w_w1_en   = 1'($urandom_range(0, 1));
         w_w1_addr = 4'($urandom_range(0, 15));
         w_w1_data = {$urandom, $urandom};
         w_iss_en  = 1'($urandom_range(0, 1));
         w_iss_addr = 4'($urandom_range(0, 15));
         for (int k = 0; k < 4; k++) begin
            case ($urandom_range(0, 3))
               0:       w_rd_addr[k*4 +: 4] = w_w0_addr;
               1:       w_rd_addr[k*4 +: 4] = w_w1_addr;
               2:       w_rd_addr[k*4 +: 4] = w_iss_addr;
               default: w_rd_addr[k*4 +: 4] = 4'($urandom_range(0, 15));
            endcase
         end
         for (int k = 0; k < 4; k++) begin
            logic [3:0] a;
            a = w_rd_addr[k*4 +: 4];
            if (a == 4'd0)
               exp_rd(2, k, 64'h0, 1'b0);
            else if (w_w1_en && w_w1_addr == a)
               exp_rd(2, k, w_w1_data, w_iss_en && w_iss_addr == a);
            else if (w_w0_en && w_w0_addr == a)
               exp_rd(2, k, w_w0_data, w_iss_en && w_iss_addr == a);
            else
               exp_rd(2, k, m_mem[a], m_busy[a]);
         end
         exp_any(2, |m_busy);
         settle();
         if (w_w0_en && w_w0_addr != 4'd0) begin
            m_mem[w_w0_addr]  = w_w0_data;
            m_busy[w_w0_addr] = 1'b0;
         end
         if (w_w1_en && w_w1_addr != 4'd0) begin
            m_mem[w_w1_addr]  = w_w1_data;
            m_busy[w_w1_addr] = 1'b0;
         end
         if (w_iss_en && w_iss_addr != 4'd0) begin
            m_busy[w_iss_addr] = 1'b1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
